// File: rtl/mem_pkg.sv
// mem_pkg: size encodings, FSM states and control opcodes shared with the control decoder.
package mem_pkg;
  localparam logic [1:0] SIZE_ILLEGAL = 2'b00;
  localparam logic [1:0] SIZE_BYTE    = 2'b01;
  localparam logic [1:0] SIZE_HALF    = 2'b10;
  localparam logic [1:0] SIZE_WORD    = 2'b11;
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, MERGE = 2'd2, RESP = 2'd3} state_t;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
endpackage

// File: rtl/data_mem_unit_if.sv
// data_mem_unit_if: MEM-stage request/response bundle between datapath and data memory.
interface data_mem_unit_if;
  logic        MemRead;
  logic        MemWrite;
  logic [1:0]  MemDataSize;
  logic        MemDataSign;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        Busy;
  logic        Done;
  logic        Error;
  modport master(output MemRead, MemWrite, MemDataSize, MemDataSign, Address, WriteData,
                 input ReadData, Busy, Done, Error);
  modport slave(input MemRead, MemWrite, MemDataSize, MemDataSign, Address, WriteData,
                output ReadData, Busy, Done, Error);
endinterface

// File: rtl/mem_lane_align.sv
// mem_lane_align: big-endian lane extract with sign/zero extension, and lane merge for stores.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        sign,
  input  logic [31:0] wdata,
  output logic [31:0] load_val,
  output logic [31:0] merged
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b = word[{~lane, 3'b000} +: 8];
    h = word[{~lane[1], 4'b0000} +: 16];
    load_val = size == SIZE_BYTE ? {{24{sign & b[7]}}, b} :
               size == SIZE_HALF ? {{16{sign & h[15]}}, h} : word;
    merged = word;
    if (size == SIZE_BYTE) merged[{~lane, 3'b000} +: 8] = wdata[7:0];
    else if (size == SIZE_HALF) merged[{~lane[1], 4'b0000} +: 16] = wdata[15:0];
    else merged = wdata;
  end
endmodule

// File: rtl/data_mem_unit.sv
// data_mem_unit: wait-stated data RAM serving LW/LH/LHU/LB/LBU and SW/SH/SB (RMW for sub-word).
// Optional misalignment trapping with DATA_MEM_ALIGN_CHECK_EN.
module data_mem_unit
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 0
) (
  input logic clk,
  input logic reset,
  data_mem_unit_if.slave bus
);
  localparam int AW = $clog2(DEPTH_WORDS);
  logic [31:0] mem [DEPTH_WORDS];
  state_t state;
  logic [3:0] cnt;
  logic err;
  logic [31:0] rdata, old_q, load_val, merged, align_word;
  logic [AW-1:0] idx;
  logic misaligned, illegal, access, we, unused_addr;
  assign idx = bus.Address[AW+1:2];
  assign unused_addr = ^bus.Address[31:AW+2];
`ifdef DATA_MEM_ALIGN_CHECK_EN
  assign misaligned = (bus.MemDataSize == SIZE_HALF && bus.Address[0]) ||
                      (bus.MemDataSize == SIZE_WORD && bus.Address[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif
  assign illegal = (bus.MemRead & bus.MemWrite) | (bus.MemDataSize == SIZE_ILLEGAL) | misaligned;
  assign access = state == WAIT && cnt == 4'd0;
  // Word stores write straight from WAIT; sub-word stores commit only in MERGE.
  assign we = (access && bus.MemWrite && bus.MemDataSize == SIZE_WORD) || state == MERGE;
  assign align_word = state == MERGE ? old_q : mem[idx];
  mem_lane_align u_align (
    .word(align_word), .lane(bus.Address[1:0]), .size(bus.MemDataSize),
    .sign(bus.MemDataSign), .wdata(bus.WriteData), .load_val(load_val), .merged(merged)
  );
  always_ff @(posedge clk)
    if (!reset && we) mem[idx] <= merged;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
      err   <= 1'b0;
      rdata <= 32'd0;
    end else begin
      case (state)
        IDLE: if (bus.MemRead || bus.MemWrite) begin
          err   <= illegal;
          cnt   <= 4'(WAIT_CYCLES);
          state <= illegal ? RESP : WAIT;
        end
        WAIT: if (cnt != 4'd0) cnt <= cnt - 4'd1;
        else begin
          old_q <= mem[idx];
          if (bus.MemRead) rdata <= load_val;
          state <= (bus.MemWrite && bus.MemDataSize != SIZE_WORD) ? MERGE : RESP;
        end
        MERGE: state <= RESP;
        default: state <= IDLE;
      endcase
    end
  end
  assign bus.ReadData = rdata;
  assign bus.Busy     = state != IDLE;
  assign bus.Done     = state == RESP && !err;
  assign bus.Error    = state == RESP && err;
endmodule

// File: tb/tb_data_mem_unit.sv
// tb_data_mem_unit: directed vector table, reset/wait-state sequences and randomized model check.
module tb_data_mem_unit;
  logic clk = 0, reset = 1;
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
`ifdef DATA_MEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif
  data_mem_unit_if b0();
  data_mem_unit_if b3();
  data_mem_unit #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut0(.clk(clk), .reset(reset), .bus(b0));
  data_mem_unit #(.DEPTH_WORDS(256), .WAIT_CYCLES(3)) dut3(.clk(clk), .reset(reset), .bus(b3));

  typedef struct {
    logic rd, wr;
    logic [1:0] size;
    logic sign;
    logic [31:0] addr, wdata, exp_rd;
    logic exp_err;
    int lat;
  } vec_t;
  vec_t tbl[18];
  logic [7:0] bytes_m [1024];
  logic [31:0] m_rd;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic run(input logic rd, wr, input logic [1:0] size, input logic sign,
                     input logic [31:0] addr, wdata,
                     output logic done, err, output int lat, output logic [31:0] rdata);
    @(negedge clk);
    b0.MemRead = rd; b0.MemWrite = wr; b0.MemDataSize = size;
    b0.MemDataSign = sign; b0.Address = addr; b0.WriteData = wdata;
    lat = 99; done = 0; err = 0; rdata = 'x;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (b0.Done || b0.Error) begin
        done = b0.Done; err = b0.Error; lat = c; rdata = b0.ReadData;
        break;
      end
    end
    b0.MemRead = 0; b0.MemWrite = 0;
    @(posedge clk); #1;
  endtask

  task automatic apply(input string name, input logic rd, wr, input logic [1:0] size,
                       input logic sign, input logic [31:0] addr, wdata,
                       input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
    logic d, e;
    int l;
    logic [31:0] r;
    run(rd, wr, size, sign, addr, wdata, d, e, l, r);
    chk({name, "_done"}, 32'(d), 32'(!exp_err));
    chk({name, "_err"}, 32'(e), 32'(exp_err));
    chk({name, "_lat"}, l, exp_lat);
    chk({name, "_rdata"}, r, exp_rd);
  endtask

  // Reference: byte-addressed big-endian memory, wrapping at 1 KiB.
  task automatic model(input logic rd, wr, input logic [1:0] size, input logic sign,
                       input logic [31:0] addr, wdata, output logic err, output int lat);
    int n, ea;
    logic [31:0] v;
    n = size == 2'b01 ? 1 : size == 2'b10 ? 2 : 4;
    err = (rd && wr) || size == 2'b00 || (ALIGN && addr % n != 0);
    ea = int'(addr % 1024) / n * n;
    lat = err ? 1 : 2 + (wr && n < 4 ? 1 : 0);
    if (err) return;
    if (rd) begin
      v = 0;
      for (int i = 0; i < n; i++) v = (v << 8) | 32'(bytes_m[ea + i]);
      if (sign && n < 4 && v[8 * n - 1]) v = v | (32'hFFFFFFFF << (8 * n));
      m_rd = v;
    end else
      for (int i = 0; i < n; i++) bytes_m[ea + i] = 8'(wdata >> (8 * (n - 1 - i)));
  endtask

  initial begin
    logic d, e, xe;
    int l, xl;
    logic [31:0] r, a, w;
    logic rd, wr, sg;
    logic [1:0] sz;
    b0.MemRead = 0; b0.MemWrite = 0; b0.MemDataSize = 0; b0.MemDataSign = 0;
    b0.Address = 0; b0.WriteData = 0;
    b3.MemRead = 0; b3.MemWrite = 0; b3.MemDataSize = 0; b3.MemDataSign = 0;
    b3.Address = 0; b3.WriteData = 0;
    tbl[0]  = '{0, 1, 2'b11, 0, 32'h10,  32'h80FF7F01, 32'h0,        0, 2};
    tbl[1]  = '{1, 0, 2'b11, 0, 32'h10,  32'h0,        32'h80FF7F01, 0, 2};
    tbl[2]  = '{1, 0, 2'b01, 1, 32'h10,  32'h0,        32'hFFFFFF80, 0, 2};
    tbl[3]  = '{1, 0, 2'b01, 0, 32'h10,  32'h0,        32'h00000080, 0, 2};
    tbl[4]  = '{1, 0, 2'b01, 1, 32'h13,  32'h0,        32'h00000001, 0, 2};
    tbl[5]  = '{1, 0, 2'b10, 1, 32'h10,  32'h0,        32'hFFFF80FF, 0, 2};
    tbl[6]  = '{1, 0, 2'b10, 0, 32'h12,  32'h0,        32'h00007F01, 0, 2};
    tbl[7]  = '{0, 1, 2'b01, 0, 32'h11,  32'hAB,       32'h00007F01, 0, 3};
    tbl[8]  = '{1, 0, 2'b11, 0, 32'h10,  32'h0,        32'h80AB7F01, 0, 2};
    tbl[9]  = '{0, 1, 2'b10, 0, 32'h12,  32'h1234,     32'h80AB7F01, 0, 3};
    tbl[10] = '{1, 0, 2'b11, 0, 32'h10,  32'h0,        32'h80AB1234, 0, 2};
    tbl[11] = '{1, 1, 2'b11, 0, 32'h10,  32'h0,        32'h80AB1234, 1, 1};
    tbl[12] = '{0, 1, 2'b00, 0, 32'h10,  32'hFFFFFFFF, 32'h80AB1234, 1, 1};
    tbl[13] = '{1, 0, 2'b11, 0, 32'h10,  32'h0,        32'h80AB1234, 0, 2};
    tbl[14] = '{0, 1, 2'b11, 0, 32'h410, 32'hDEADBEEF, 32'h80AB1234, 0, 2};
    tbl[15] = '{1, 0, 2'b11, 0, 32'h10,  32'h0,        32'hDEADBEEF, 0, 2};
    tbl[16] = '{1, 0, 2'b11, 0, 32'h11,  32'h0,        32'hDEADBEEF, ALIGN, ALIGN ? 1 : 2};
    tbl[17] = '{1, 0, 2'b10, 1, 32'h13,  32'h0,        ALIGN ? 32'hDEADBEEF : 32'hFFFFBEEF, ALIGN, ALIGN ? 1 : 2};
    repeat (3) @(posedge clk);
    #1 reset = 0;
    chk("rst_busy", 32'(b0.Busy), 0);
    chk("rst_done", 32'(b0.Done), 0);
    chk("rst_error", 32'(b0.Error), 0);
    chk("rst_rdata", b0.ReadData, 0);
    for (int i = 0; i < 18; i++)
      apply($sformatf("vec%0d", i), tbl[i].rd, tbl[i].wr, tbl[i].size, tbl[i].sign,
            tbl[i].addr, tbl[i].wdata, tbl[i].exp_rd, tbl[i].exp_err, tbl[i].lat);
    // Three wait states: Busy spans cycles 1..5, Done only in 5.
    @(negedge clk);
    b3.MemRead = 1; b3.MemDataSize = 2'b11; b3.Address = 32'h20;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      chk($sformatf("w3_busy_c%0d", c), 32'(b3.Busy), 32'(c <= 5));
      chk($sformatf("w3_done_c%0d", c), 32'(b3.Done), 32'(c == 5));
      if (c == 5) b3.MemRead = 0;
    end
    // Reset while an SB sits in MERGE: the word must keep its old value.
    @(negedge clk);
    b0.MemRead = 0; b0.MemWrite = 1; b0.MemDataSize = 2'b01; b0.Address = 32'h10; b0.WriteData = 32'h11;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rmw_busy_merge", 32'(b0.Busy), 1);
    reset = 1;
    @(posedge clk); #1;
    chk("rmw_rst_busy", 32'(b0.Busy), 0);
    chk("rmw_rst_done", 32'(b0.Done), 0);
    chk("rmw_rst_rdata", b0.ReadData, 0);
    reset = 0; b0.MemWrite = 0;
    @(posedge clk); #1;
    apply("rmw_after", 1, 0, 2'b11, 0, 32'h10, 0, 32'hDEADBEEF, 0, 2);
    m_rd = 32'hDEADBEEF;
    for (int i = 0; i < 32; i++) begin
      w = $urandom;
      model(0, 1, 2'b11, 0, 32'(i * 4), w, xe, xl);
      apply($sformatf("init%0d", i), 0, 1, 2'b11, 0, 32'(i * 4), w, m_rd, 0, 2);
    end
    for (int i = 0; i < 150; i++) begin
      l = int'($urandom_range(0, 9));
      rd = l != 0 && l <= 5 || l == 0;
      wr = l == 0 || l >= 6;
      sz = $urandom_range(0, 12) == 0 ? 2'b00 : 2'($urandom_range(1, 3));
      sg = 1'($urandom);
      a = $urandom_range(0, 127) | ($urandom_range(0, 3) << 10);
      w = $urandom;
      model(rd, wr, sz, sg, a, w, xe, xl);
      apply($sformatf("rnd%0d", i), rd, wr, sz, sg, a, w, m_rd, xe, xl);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
